// File: rtl/cp0_intc.sv
// Coprocessor-0 with interrupt controller and Count/Compare timer for the 5-stage MIPS core.
// Holds SR/Cause/EPC/PRId/Count/Compare and raises the M-stage flush/redirect request.
module cp0_intc #(
    parameter int unsigned NUM_HWINT   = 5,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned COUNT_DIV   = 1,
    parameter logic [31:0] PRID        = 32'h0000_7C01
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [4:0]           addr_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o,
    input  logic [31:0]          vpc_i,
    input  logic                 bd_in_i,
    input  logic [4:0]           exc_code_in_i,
    input  logic [NUM_HWINT-1:0] hwint_i,
    input  logic                 exl_clr_i,
    output logic [31:0]          epc_out_o,
    output logic                 req_o,
    output logic                 int_response_o
);

    localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [5:0]  IM_MASK = 6'h20 | 6'((32'd1 << NUM_HWINT) - 32'd1);

    logic [5:0]    im_q, im_d;
    logic          exl_q, exl_d;
    logic          ie_q, ie_d;
    logic          bd_q, bd_d;
    logic [4:0]    exc_q, exc_d;
    logic          tpend_q, tpend_d;
    logic [31:0]   epc_q, epc_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic [PW-1:0] pre_q, pre_d;

    logic [NUM_HWINT-1:0] hw_sync;
    logic [4:0]           hw_ip;
    logic [5:0]           ip;
    logic                 int_req, exc_req, tick;
    logic [31:0]          count_inc, vpc_al;

    // Level synchroniser for the asynchronous interrupt lines
    if (SYNC_STAGES == 0) begin : g_nosync
        assign hw_sync = hwint_i;
    end else begin : g_sync
        logic [NUM_HWINT-1:0] sync_q [SYNC_STAGES];
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
            end else begin
                sync_q[0] <= hwint_i;
                for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
            end
        end
        assign hw_sync = sync_q[SYNC_STAGES-1];
    end

    assign hw_ip     = 5'(hw_sync);
    assign ip        = {tpend_q, hw_ip};
    assign int_req   = ie_q & ~exl_q & (|(ip & im_q));
    assign exc_req   = (exc_code_in_i != 5'd0) & ~exl_q;
    assign tick      = (pre_q == PW'(COUNT_DIV - 1));
    assign count_inc = count_q + 32'd1;
    assign vpc_al    = vpc_i & ~32'h3;

    assign req_o          = int_req | exc_req;
    assign int_response_o = int_req;
    assign epc_out_o      = (en_i && addr_i == 5'd14 && !req_o) ? wdata_i : epc_q;

    always_comb begin
        case (addr_i)
            5'd9:    rdata_o = count_q;
            5'd11:   rdata_o = compare_q;
            5'd12:   rdata_o = {16'b0, im_q, 8'b0, exl_q, ie_q};
            5'd13:   rdata_o = {bd_q, 15'b0, ip, 3'b0, exc_q, 2'b0};
            5'd14:   rdata_o = epc_q;
            5'd15:   rdata_o = PRID;
            default: rdata_o = 32'd0;
        endcase
    end

    // Next state: timer, then exception entry > eret > mtc0 priority
    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        exc_d     = exc_q;
        tpend_d   = tpend_q;
        epc_d     = epc_q;
        count_d   = count_q;
        compare_d = compare_q;
        pre_d     = pre_q + PW'(1);

        if (tick) begin
            pre_d   = '0;
            count_d = count_inc;
            if (count_inc == compare_q) tpend_d = 1'b1;
        end

        if (req_o) begin
            exl_d = 1'b1;
            exc_d = int_req ? 5'd0 : exc_code_in_i;
            bd_d  = bd_in_i;
            epc_d = bd_in_i ? vpc_al - 32'd4 : vpc_al;
        end else if (exl_clr_i) begin
            exl_d = 1'b0;
        end else if (en_i) begin
            case (addr_i)
                5'd9: begin
                    count_d = wdata_i;
                    pre_d   = '0;
                end
                5'd11: begin
                    compare_d = wdata_i;
                    tpend_d   = 1'b0;
                end
                5'd12: begin
                    im_d  = wdata_i[15:10] & IM_MASK;
                    exl_d = wdata_i[1];
                    ie_d  = wdata_i[0];
                end
                5'd14:   epc_d = wdata_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            im_q      <= '0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            exc_q     <= '0;
            tpend_q   <= 1'b0;
            epc_q     <= '0;
            count_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            pre_q     <= '0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            exc_q     <= exc_d;
            tpend_q   <= tpend_d;
            epc_q     <= epc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            pre_q     <= pre_d;
        end
    end

endmodule

// File: tb/tb_cp0_intc.sv
// Directed self-checking bench for cp0_intc with default parameters.
module tb_cp0_intc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code;
    logic [4:0]  hwint;
    logic        exl_clr;
    logic [31:0] epc_out;
    logic        req;
    logic        int_resp;

    int n_chk  = 0;
    int n_fail = 0;

    cp0_intc dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .en_i           (en),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .rdata_o        (rdata),
        .vpc_i          (vpc),
        .bd_in_i        (bd_in),
        .exc_code_in_i  (exc_code),
        .hwint_i        (hwint),
        .exl_clr_i      (exl_clr),
        .epc_out_o      (epc_out),
        .req_o          (req),
        .int_response_o (int_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        en = 1'b1; addr = a; wdata = d;
        tick();
        en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; addr = '0; wdata = '0; vpc = '0; bd_in = 1'b0;
        exc_code = '0; hwint = '0; exl_clr = 1'b0;
        #22 rst_n = 1'b1;
        #1;

        // 1: reset values
        rd(5'd12, 32'h0, "rst_sr");
        rd(5'd13, 32'h0, "rst_cause");
        rd(5'd14, 32'h0, "rst_epc");
        rd(5'd15, 32'h0000_7C01, "rst_prid");
        rd(5'd11, 32'hFFFF_FFFF, "rst_compare");
        rd(5'd3, 32'h0, "rst_unused");
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_epc_out", epc_out, 32'h0);

        // 2: hw interrupt through 2-stage synchroniser
        mtc0(5'd12, 32'h0000_0401);
        rd(5'd12, 32'h0000_0401, "sr_write");
        hwint = 5'b00001;
        #1;
        chk("hw_req_e0", 32'(req), 32'h0);
        tick();
        chk("hw_req_e1", 32'(req), 32'h0);
        tick();
        chk("hw_req_e2", 32'(req), 32'h1);
        chk("hw_intresp", 32'(int_resp), 32'h1);
        vpc = 32'h0000_1007;
        tick();
        chk("hw_req_drop", 32'(req), 32'h0);
        rd(5'd12, 32'h0000_0403, "hw_sr");
        rd(5'd13, 32'h0000_0400, "hw_cause");
        rd(5'd14, 32'h0000_1004, "hw_epc");
        chk("hw_epc_out", epc_out, 32'h0000_1004);

        // 3: exception in delay slot
        hwint = '0;
        tick(); tick();
        exl_clr = 1'b1;
        tick();
        exl_clr = 1'b0;
        rd(5'd12, 32'h0000_0401, "eret_sr");
        chk("eret_req", 32'(req), 32'h0);
        exc_code = 5'd12; bd_in = 1'b1; vpc = 32'h0000_3008;
        #1;
        chk("exc_req", 32'(req), 32'h1);
        chk("exc_intresp", 32'(int_resp), 32'h0);
        tick();
        exc_code = '0; bd_in = 1'b0;
        rd(5'd14, 32'h0000_3004, "exc_epc");
        rd(5'd13, 32'h8000_0030, "exc_cause");
        rd(5'd12, 32'h0000_0403, "exc_sr");
        en = 1'b1; wdata = 32'h0000_ABCD; addr = 5'd14;
        #1;
        chk("epc_bypass", epc_out, 32'h0000_ABCD);
        chk("epc_no_rd_bypass", rdata, 32'h0000_3004);
        en = 1'b0;

        // 6: eret with interrupt held -> req only after EXL clears
        hwint = 5'b00001;
        tick(); tick();
        exl_clr = 1'b1;
        #1;
        chk("eret_hold_req", 32'(req), 32'h0);
        tick();
        exl_clr = 1'b0;
        #1;
        rd(5'd12, 32'h0000_0401, "eret_exl0");
        chk("eret_then_req", 32'(req), 32'h1);
        chk("eret_then_int", 32'(int_resp), 32'h1);

        // 4: interrupt + exception + mtc0 EPC together
        exc_code = 5'd5; vpc = 32'h0000_2000; bd_in = 1'b0;
        en = 1'b1; addr = 5'd14; wdata = 32'h0000_1234;
        #1;
        chk("coll_epc_out", epc_out, 32'h0000_3004);
        tick();
        en = 1'b0; exc_code = '0;
        rd(5'd13, 32'h0000_0400, "coll_cause");
        rd(5'd14, 32'h0000_2000, "coll_epc");
        rd(5'd12, 32'h0000_0403, "coll_sr");

        // 5: Count/Compare timer
        hwint = '0;
        tick(); tick();
        exl_clr = 1'b1;
        tick();
        exl_clr = 1'b0;
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd10);
        mtc0(5'd9, 32'd0);
        for (int i = 0; i < 9; i++) tick();
        rd(5'd9, 32'd9, "tmr_count9");
        chk("tmr_req9", 32'(req), 32'h0);
        tick();
        rd(5'd9, 32'd10, "tmr_count10");
        rd(5'd13, 32'h0000_8000, "tmr_ip15");
        chk("tmr_req10", 32'(req), 32'h1);
        chk("tmr_int10", 32'(int_resp), 32'h1);
        tick();
        rd(5'd12, 32'h0000_8003, "tmr_sr");
        rd(5'd13, 32'h0000_8000, "tmr_sticky");
        mtc0(5'd11, 32'h0000_0100);
        rd(5'd13, 32'h0000_0000, "tmr_clear");
        mtc0(5'd9, 32'hFFFF_FFFF);
        rd(5'd9, 32'hFFFF_FFFF, "tmr_load");
        tick();
        rd(5'd9, 32'h0000_0000, "tmr_wrap");
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd(5'd12, 32'h0000_FC03, "sr_mask");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
